// File: rtl/act_unit_driver.sv
// Drives a single en/done activation unit from a 2-deep operand FIFO and
// returns each result (or a timeout error) on a valid/ready output stream.
module act_unit_driver #(
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_err,
   output logic          act_en,
   output logic [DW-1:0] act_data_in,
   input  logic          act_done,
   input  logic [DW-1:0] act_data_out,
   output logic          busy,
   output logic [15:0]   op_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    r_state;
   logic [DW-1:0] r_mem [2];
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_count;
   logic          r_in_ready;
   logic [7:0]    r_wait_cnt;
   logic          r_out_valid;
   logic [DW-1:0] r_out_data;
   logic          r_out_err;
   logic          r_act_en;
   logic [DW-1:0] r_act_data_in;
   logic [15:0]   r_op_count;

   logic          w_push;
   logic          w_pop;
   logic [1:0]    w_count_next;
   logic          w_timeout;

   // in_ready is registered as !full, so a full FIFO refuses a push even
   // when the head is popped in the same cycle.
   assign w_push       = in_valid && r_in_ready;
   assign w_pop        = (r_state == S_IDLE) && (r_count != 2'd0);
   assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
   assign w_timeout    = (r_wait_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state       <= S_IDLE;
         r_mem[0]      <= '0;
         r_mem[1]      <= '0;
         r_wr_ptr      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         r_count       <= 2'd0;
         r_in_ready    <= 1'b1;
         r_wait_cnt    <= 8'd0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_err     <= 1'b0;
         r_act_en      <= 1'b0;
         r_act_data_in <= '0;
         r_op_count    <= 16'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count    <= w_count_next;
         r_in_ready <= (w_count_next != 2'd2);

         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_act_data_in <= r_mem[r_rd_ptr];
                  r_act_en      <= 1'b1;
                  r_wait_cnt    <= 8'd0;
                  r_state       <= S_WAIT;
               end
            end
            // act_done is only looked at here, so a stale done left over
            // from the previous operation can never complete a new one.
            S_WAIT: begin
               if (act_done) begin
                  r_out_data  <= act_data_out;
                  r_out_err   <= 1'b0;
                  r_act_en    <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else if (w_timeout) begin
                  r_out_data  <= '0;
                  r_out_err   <= 1'b1;
                  r_act_en    <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            S_RESP: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_op_count  <= r_op_count + 16'd1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_err     = r_out_err;
   assign act_en      = r_act_en;
   assign act_data_in = r_act_data_in;
   assign op_count    = r_op_count;
   assign busy        = (r_state != S_IDLE) || (r_count != 2'd0);

endmodule

// File: tb/tb_act_unit_driver.sv
// Directed bench for act_unit_driver with a small behavioural activation unit
// (latency 3 for operand 0, latency 1 otherwise, optionally never done).
module tb_act_unit_driver;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_err;
   logic        act_en;
   logic [31:0] act_data_in;
   logic        act_done;
   logic [31:0] act_data_out;
   logic        busy;
   logic [15:0] op_count;

   int checks = 0;
   int failures = 0;

   act_unit_driver #(.DW(32), .TIMEOUT(15)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
      .act_en(act_en), .act_data_in(act_data_in), .act_done(act_done), .act_data_out(act_data_out),
      .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Behavioural unit: done rises after the programmed number of enabled
   // edges and stays high until act_en drops.
   logic done_kill = 1'b0;
   int   u_cnt;
   logic u_done;

   function automatic logic [31:0] unit_res(input logic [31:0] x);
      if (x == 32'h0) return 32'h0000_2C4F;
      return x;
   endfunction

   function automatic int unit_lat(input logic [31:0] x);
      return (x == 32'h0) ? 3 : 1;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         u_cnt  <= 0;
         u_done <= 1'b0;
      end else if (!act_en) begin
         u_cnt  <= 0;
         u_done <= 1'b0;
      end else if (!done_kill) begin
         if (u_cnt == unit_lat(act_data_in) - 1) u_done <= 1'b1;
         else u_cnt <= u_cnt + 1;
      end
   end

   assign act_done     = u_done;
   assign act_data_out = u_done ? unit_res(act_data_in) : 32'hDEAD_BEEF;

   // act_en high/low run lengths and a scoreboard of accepted results.
   int          en_run = 0, en_len = 0, lo_run = 0, lo_len = 0;
   logic        ov_seen = 1'b0;
   logic [32:0] resq[$];

   always @(posedge clk) begin
      if (act_en) begin
         if (lo_run != 0) lo_len = lo_run;
         lo_run = 0;
         en_run++;
      end else begin
         if (en_run != 0) en_len = en_run;
         en_run = 0;
         lo_run++;
      end
      if (out_valid) ov_seen = 1'b1;
      if (rstn && out_valid && out_ready) resq.push_back({out_err, out_data});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push1(input logic [31:0] d);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_ov(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_data"}, 64'(out_data), 64'd0);
      check({tag, "_out_err"}, 64'(out_err), 64'd0);
      check({tag, "_act_en"}, 64'(act_en), 64'd0);
      check({tag, "_act_data_in"}, 64'(act_data_in), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_op_count"}, 64'(op_count), 64'd0);
   endtask

   initial begin
      int          c;
      logic [32:0] e;
      logic [31:0] vals [3];
      vals[0] = 32'h0000_0000;
      vals[1] = 32'h7000_0000;
      vals[2] = 32'h6000_0000;

      // Reset state
      #12;
      check_reset_vals("rst");
      @(negedge clk);
      rstn = 1'b1;
      out_ready = 1'b1;

      // Linear-region op: act_en high 4 cycles, result 5 cycles after accept
      push1(32'h0);
      wait_ov(c);
      check("lin_latency", 64'(c), 64'd5);
      check("lin_data", 64'(out_data), 64'h2C4F);
      check("lin_err", 64'(out_err), 64'd0);
      @(negedge clk);
      check("lin_en_len", 64'(en_len), 64'd4);
      check("lin_op_count", 64'(op_count), 64'd1);
      check("lin_ov_clear", 64'(out_valid), 64'd0);
      $display("txn lin: in=00000000 out=%h err=%0d en_cycles=%0d", 32'h2C4F, 0, en_len);

      // Saturating op, then next op pushed immediately: low gap of 2
      push1(32'h7000_0000);
      wait_ov(c);
      check("sat_latency", 64'(c), 64'd3);
      check("sat_data", 64'(out_data), 64'h7000_0000);
      check("sat_err", 64'(out_err), 64'd0);
      in_valid = 1'b1;
      in_data  = 32'h6000_0000;
      @(negedge clk);
      in_valid = 1'b0;
      check("sat_en_len", 64'(en_len), 64'd2);
      check("sat_op_count", 64'(op_count), 64'd2);
      wait_ov(c);
      check("b2b_latency", 64'(c), 64'd3);
      check("b2b_data", 64'(out_data), 64'h6000_0000);
      @(negedge clk);
      check("b2b_low_gap", 64'(lo_len), 64'd2);
      check("b2b_op_count", 64'(op_count), 64'd3);
      $display("txn sat: in=70000000 then 60000000 low_gap=%0d", lo_len);

      // Timeout: done never asserted
      done_kill = 1'b1;
      push1(32'h1234_5678);
      @(negedge clk);
      check("to_act_en", 64'(act_en), 64'd1);
      check("to_act_data_in", 64'(act_data_in), 64'h1234_5678);
      check("to_busy", 64'(busy), 64'd1);
      wait_ov(c);
      check("to_latency", 64'(c), 64'd15);
      check("to_data", 64'(out_data), 64'd0);
      check("to_err", 64'(out_err), 64'd1);
      @(negedge clk);
      check("to_en_len", 64'(en_len), 64'd15);
      check("to_op_count", 64'(op_count), 64'd4);
      $display("txn timeout: in=12345678 en_cycles=%0d", en_len);
      done_kill = 1'b0;

      // Backpressure: three pushes accepted, fourth refused, in-order results
      resq.delete();
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = vals[i];
         check("bp_in_ready_push", 64'(in_ready), 64'd1);
         @(negedge clk);
      end
      in_data = 32'h1111_1111;
      check("bp_in_ready_full", 64'(in_ready), 64'd0);
      repeat (3) @(negedge clk);
      check("bp_in_ready_held", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      repeat (14) @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_hold", 64'(out_data), 64'h2C4F);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_no_result", 64'(resq.size()), 64'd0);
      out_ready = 1'b1;
      repeat (30) @(negedge clk);
      check("bp_result_count", 64'(resq.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         e = (resq.size() > i) ? resq[i] : 33'h1_FFFF_FFFF;
         check("bp_result", 64'(e), 64'({1'b0, unit_res(vals[i])}));
         $display("txn bp[%0d]: in=%h out=%h err=%0d", i, vals[i], e[31:0], e[32]);
      end
      check("bp_op_count", 64'(op_count), 64'd7);
      check("bp_idle_busy", 64'(busy), 64'd0);
      check("bp_idle_in_ready", 64'(in_ready), 64'd1);

      // Reset during WAIT with one entry buffered
      resq.delete();
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h0;
      @(negedge clk);
      in_data  = 32'h7000_0000;
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_act_en", 64'(act_en), 64'd1);
      check("mid_busy", 64'(busy), 64'd1);
      rstn = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      ov_seen = 1'b0;
      repeat (10) @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_no_ov", 64'(ov_seen), 64'd0);
      check("post_rst_act_en", 64'(act_en), 64'd0);
      check("post_rst_op_count", 64'(op_count), 64'd0);
      $display("txn reset_mid_wait: busy=%0d ov_seen=%0d", busy, ov_seen);

      // op_count wrap
      @(negedge clk);
      force dut.r_op_count = 16'hFFFF;
      #1;
      release dut.r_op_count;
      check("wrap_preset", 64'(op_count), 64'hFFFF);
      push1(32'h7000_0000);
      wait_ov(c);
      check("wrap_data", 64'(out_data), 64'h7000_0000);
      @(negedge clk);
      check("wrap_op_count", 64'(op_count), 64'h0000);
      $display("txn wrap: op_count=%h", op_count);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
